// File: rtl/fp_status_pkg.sv
// Shared definitions for the FP multiplier status monitor: rule indices,
// status-byte bit positions, FSM states and a small priority helper.
package fp_status_pkg;

  // Number of consistency rules checked on every observed status byte.
  localparam int NUM_RULES = 9;

  // Rule indices; bit i of viol/sticky and counter i belong to rule i.
  localparam int R_ZERO_INF  = 0;  // zero_f together with inf_f
  localparam int R_ZERO_NAN  = 1;  // zero_f together with nan_f
  localparam int R_INF_NAN   = 2;  // inf_f together with nan_f
  localparam int R_HUGE_TINY = 3;  // huge_f together with tiny_f
  localparam int R_ZERO_EXP  = 4;  // zero_f but exponent of z is not 0
  localparam int R_INF_EXP   = 5;  // inf_f but exponent of z is not all-ones
  localparam int R_NAN_OPS   = 6;  // nan_f without a 0 x inf operand pair
  localparam int R_HUGE      = 7;  // huge_f but z is not at/near the top
  localparam int R_TINY      = 8;  // tiny_f but z is not at/near the bottom

  // Bit positions inside the 8-bit status byte.
  localparam int ST_OVERFLOW  = 7;
  localparam int ST_UNDERFLOW = 6;
  localparam int ST_ZERO      = 5;
  localparam int ST_INF       = 4;
  localparam int ST_NAN       = 3;
  localparam int ST_TINY      = 2;
  localparam int ST_HUGE      = 1;
  localparam int ST_INEXACT   = 0;

  // Monitor control states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } mon_state_t;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [3:0] lowest_rule(input logic [NUM_RULES-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = NUM_RULES - 1; i >= 0; i--) begin
      idx = v[i] ? 4'(i) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/fp_status_delay.sv
// Fixed-length shift register that re-times the operand side-band
// (valid flag and both operand exponents) to line up with z/status.
// Reset empties the line so in-flight operations are never checked;
// there is deliberately no synchronous flush.
module fp_status_delay #(
  parameter int LATENCY = 3,
  parameter int WIDTH   = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [LATENCY];

  // Advance every stage by one per clock; reset clears all stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < LATENCY; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[LATENCY-1];

endmodule

// File: rtl/fp_status_monitor.sv
// Runtime checker for the status byte of the pipelined FP multiplier.
// Observes a/b/z/status only. Each checked cycle evaluates nine
// consistency rules, keeps saturating per-rule counters, sticky flags,
// a first-failure snapshot and an optional freeze-on-error state.
module fp_status_monitor
  import fp_status_pkg::*;
#(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int LATENCY = 3,
  parameter int CNT_W   = 16,
  localparam int W      = 1 + EXP_W + MAN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 freeze_on_err,
  input  logic                 in_valid,
  input  logic [W-1:0]         a,
  input  logic [W-1:0]         b,
  input  logic [W-1:0]         z,
  input  logic [7:0]           status,
  input  logic [3:0]           rd_sel,
  output logic [NUM_RULES-1:0] viol,
  output logic [NUM_RULES-1:0] sticky,
  output logic                 err_any,
  output logic [CNT_W-1:0]     rd_cnt,
  output logic [3:0]           first_rule,
  output logic [W-1:0]         first_z,
  output logic [CNT_W-1:0]     first_time,
  output logic                 frozen
);

  localparam int DL_W = 2 * EXP_W + 1;

  localparam logic [EXP_W-1:0] EXP_ZERO = '0;
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
  localparam logic [EXP_W-1:0] EXP_MAXF = EXP_ONES - EXP_W'(1);
  localparam logic [MAN_W-1:0] MAN_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Operand side-band delay line
  logic [DL_W-1:0]  w_dl_in;
  logic [DL_W-1:0]  w_dl_out;
  logic             w_chk_v;
  logic [EXP_W-1:0] w_exp_a_d;
  logic [EXP_W-1:0] w_exp_b_d;

  // Result fields and rule evaluation
  logic [EXP_W-1:0]     w_exp_z;
  logic [MAN_W-1:0]     w_man_z;
  logic                 w_status_known;
  logic                 w_check;
  logic [NUM_RULES-1:0] w_rule;
  logic [NUM_RULES-1:0] w_viol_now;
  logic                 w_any;
  logic                 w_zero_pair;

  // Control and bookkeeping state
  mon_state_t           r_state;
  mon_state_t           w_state_nxt;
  logic                 r_frozen;
  logic [CNT_W-1:0]     r_cnt [NUM_RULES];
  logic [NUM_RULES-1:0] r_viol;
  logic [NUM_RULES-1:0] r_sticky;
  logic                 r_err_any;
  logic [3:0]           r_first_rule;
  logic [W-1:0]         r_first_z;
  logic [CNT_W-1:0]     r_first_time;
  logic [CNT_W-1:0]     r_ts;

  // Bits of the observed buses that no rule looks at.
  logic w_unused;
  assign w_unused = ^{a[W-1], a[MAN_W-1:0], b[W-1], b[MAN_W-1:0], z[W-1],
                      status[ST_OVERFLOW], status[ST_UNDERFLOW], status[ST_INEXACT]};

  assign w_dl_in = {in_valid, a[W-2 -: EXP_W], b[W-2 -: EXP_W]};

  fp_status_delay #(
    .LATENCY (LATENCY),
    .WIDTH   (DL_W)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .i_d (w_dl_in),
    .o_q (w_dl_out)
  );

  assign w_chk_v   = w_dl_out[DL_W-1];
  assign w_exp_a_d = w_dl_out[DL_W-2 -: EXP_W];
  assign w_exp_b_d = w_dl_out[EXP_W-1:0];

  assign w_exp_z = z[W-2 -: EXP_W];
  assign w_man_z = z[MAN_W-1:0];

  // An unknown status byte is treated as carrying no violation.
  assign w_status_known = !$isunknown(status);
  assign w_check        = w_chk_v && (r_state == RUN) && w_status_known;

  // A NaN result is only legitimate for a 0 x inf operand pair.
  assign w_zero_pair = ((w_exp_a_d == EXP_ZERO) && (w_exp_b_d == EXP_ONES)) ||
                       ((w_exp_b_d == EXP_ZERO) && (w_exp_a_d == EXP_ONES));

  // Evaluate all consistency rules against the current z/status.
  always_comb begin
    w_rule = '0;
    w_rule[R_ZERO_INF]  = status[ST_ZERO] & status[ST_INF];
    w_rule[R_ZERO_NAN]  = status[ST_ZERO] & status[ST_NAN];
    w_rule[R_INF_NAN]   = status[ST_INF]  & status[ST_NAN];
    w_rule[R_HUGE_TINY] = status[ST_HUGE] & status[ST_TINY];
    w_rule[R_ZERO_EXP]  = status[ST_ZERO] & (w_exp_z != EXP_ZERO);
    w_rule[R_INF_EXP]   = status[ST_INF]  & (w_exp_z != EXP_ONES);
    w_rule[R_NAN_OPS]   = status[ST_NAN]  & !w_zero_pair;
    w_rule[R_HUGE]      = status[ST_HUGE] &
                          !((w_exp_z == EXP_ONES) ||
                            ((w_exp_z == EXP_MAXF) && (&w_man_z)));
    w_rule[R_TINY]      = status[ST_TINY] &
                          !((w_exp_z == EXP_ZERO) ||
                            ((w_exp_z == EXP_ONE) && (w_man_z == MAN_ZERO)));
  end

  assign w_viol_now = w_check ? w_rule : '0;
  assign w_any      = |w_viol_now;

  // Next-state logic; clr overrides everything, FROZEN only leaves on clr.
  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = en ? RUN : IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (en) begin
            w_state_nxt = RUN;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        RUN: begin
          // A freeze request beats a same-cycle disable.
          if (w_any && freeze_on_err) begin
            w_state_nxt = FROZEN;
          end else if (!en) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = RUN;
          end
        end
        FROZEN: begin
          w_state_nxt = FROZEN;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State register with a registered frozen indication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_frozen <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_frozen <= (w_state_nxt == FROZEN);
    end
  end

  // Per-rule saturating violation counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_RULES; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < NUM_RULES; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_RULES; i++) begin
        if (w_viol_now[i] && (r_cnt[i] != CNT_MAX)) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Violation flags, sticky flags, first-failure snapshot and timestamp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_viol       <= '0;
      r_sticky     <= '0;
      r_err_any    <= 1'b0;
      r_first_rule <= 4'd0;
      r_first_z    <= '0;
      r_first_time <= '0;
      r_ts         <= '0;
    end else if (clr) begin
      r_viol       <= '0;
      r_sticky     <= '0;
      r_err_any    <= 1'b0;
      r_first_rule <= 4'd0;
      r_first_z    <= '0;
      r_first_time <= '0;
      r_ts         <= '0;
    end else begin
      r_viol    <= w_viol_now;
      r_sticky  <= r_sticky | w_viol_now;
      r_err_any <= |(r_sticky | w_viol_now);
      // The snapshot belongs to the first violating cycle since clear.
      if ((r_sticky == '0) && w_any) begin
        r_first_rule <= lowest_rule(w_viol_now);
        r_first_z    <= z;
        r_first_time <= r_ts;
      end
      if (r_state == RUN) begin
        r_ts <= r_ts + CNT_W'(1);
      end
    end
  end

  // Counter readback; indices past the last rule read as zero.
  always_comb begin
    rd_cnt = '0;
    for (int i = 0; i < NUM_RULES; i++) begin
      if (rd_sel == 4'(i)) begin
        rd_cnt = r_cnt[i];
      end else begin
        rd_cnt = rd_cnt;
      end
    end
  end

  assign viol       = r_viol;
  assign sticky     = r_sticky;
  assign err_any    = r_err_any;
  assign first_rule = r_first_rule;
  assign first_z    = r_first_z;
  assign first_time = r_first_time;
  assign frozen     = r_frozen;

endmodule

// File: tb/tb_fp_status_monitor.sv
// Self-checking bench: two monitors (16-bit and 4-bit counters) share one
// randomized stimulus stream and are compared every cycle against a
// queue-based reference model of the checking rules.
module tb_fp_status_monitor;

  localparam int LAT = 3;
  localparam int NR  = 9;
  localparam int S_IDLE = 0, S_RUN = 1, S_FROZEN = 2;

  logic        clk = 1'b0;
  logic        rst, en, clr, freeze_on_err, in_valid;
  logic [31:0] a, b, z;
  logic [7:0]  status;
  logic [3:0]  rd_sel;

  logic [8:0]  v16, s16, v4, s4;
  logic        e16, e4, f16, f4;
  logic [15:0] c16, t16;
  logic [3:0]  c4, t4, r16, r4;
  logic [31:0] z16, z4;

  fp_status_monitor u_dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .freeze_on_err(freeze_on_err),
    .in_valid(in_valid), .a(a), .b(b), .z(z), .status(status), .rd_sel(rd_sel),
    .viol(v16), .sticky(s16), .err_any(e16), .rd_cnt(c16), .first_rule(r16),
    .first_z(z16), .first_time(t16), .frozen(f16));

  fp_status_monitor #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .freeze_on_err(freeze_on_err),
    .in_valid(in_valid), .a(a), .b(b), .z(z), .status(status), .rd_sel(rd_sel),
    .viol(v4), .sticky(s4), .err_any(e4), .rd_cnt(c4), .first_rule(r4),
    .first_z(z4), .first_time(t4), .frozen(f4));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  typedef struct packed { bit v; bit [7:0] ea; bit [7:0] eb; } dl_t;
  dl_t      dq[$];
  int       m_cnt[NR];
  bit [8:0] m_viol, m_sticky;
  int       m_frule, m_ftime, m_ts, m_state;
  bit [31:0] m_fz;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    dq.delete();
    for (int i = 0; i < LAT; i++) dq.push_back('0);
    for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    m_viol = '0; m_sticky = '0; m_frule = 0; m_ftime = 0; m_ts = 0;
    m_fz = '0; m_state = S_IDLE;
  endtask

  // One clock of the model, using the inputs present before the edge.
  task automatic model_step();
    dl_t old;
    bit [8:0] v;
    bit [7:0] ez;
    bit [22:0] mz;
    bit zf, inf, nan, tiny, huge;
    if (rst) begin
      model_reset();
      return;
    end
    old = dq.pop_front();
    dq.push_back('{in_valid, a[30:23], b[30:23]});
    ez = z[30:23]; mz = z[22:0];
    zf = status[5]; inf = status[4]; nan = status[3]; tiny = status[2]; huge = status[1];
    v = '0;
    if (m_state == S_RUN && old.v) begin
      v[0] = zf && inf;
      v[1] = zf && nan;
      v[2] = inf && nan;
      v[3] = huge && tiny;
      v[4] = zf && (ez != 0);
      v[5] = inf && (ez != 255);
      v[6] = nan && !((old.ea == 0 && old.eb == 255) || (old.eb == 0 && old.ea == 255));
      v[7] = huge && !(ez == 255 || (ez == 254 && mz == 23'h7FFFFF));
      v[8] = tiny && !(ez == 0 || (ez == 1 && mz == 0));
    end
    if (clr) begin
      for (int i = 0; i < NR; i++) m_cnt[i] = 0;
      m_viol = '0; m_sticky = '0; m_frule = 0; m_ftime = 0; m_fz = '0; m_ts = 0;
      m_state = en ? S_RUN : S_IDLE;
      return;
    end
    m_viol = v;
    for (int i = 0; i < NR; i++) if (v[i]) m_cnt[i]++;
    if (m_sticky == 0 && v != 0) begin
      for (int i = NR - 1; i >= 0; i--) if (v[i]) m_frule = i;
      m_fz = z;
      m_ftime = m_ts;
    end
    m_sticky |= v;
    if (m_state == S_RUN) m_ts++;
    if (m_state == S_IDLE) begin
      if (en) m_state = S_RUN;
    end else if (m_state == S_RUN) begin
      if (v != 0 && freeze_on_err) m_state = S_FROZEN;
      else if (!en) m_state = S_IDLE;
    end
  endtask

  function automatic int exp_cnt(input int sel, input int sat);
    if (sel >= NR) return 0;
    return (m_cnt[sel] > sat) ? sat : m_cnt[sel];
  endfunction

  task automatic check_all();
    check_val("viol16", v16, m_viol);
    check_val("sticky16", s16, m_sticky);
    check_val("err_any16", e16, |m_sticky);
    check_val("rd_cnt16", c16, exp_cnt(int'(rd_sel), 65535));
    check_val("first_rule16", r16, m_frule);
    check_val("first_z16", z16, m_fz);
    check_val("first_time16", t16, m_ftime % 65536);
    check_val("frozen16", f16, m_state == S_FROZEN);
    check_val("viol4", v4, m_viol);
    check_val("sticky4", s4, m_sticky);
    check_val("err_any4", e4, |m_sticky);
    check_val("rd_cnt4", c4, exp_cnt(int'(rd_sel), 15));
    check_val("first_rule4", r4, m_frule);
    check_val("first_z4", z4, m_fz);
    check_val("first_time4", t4, m_ftime % 16);
    check_val("frozen4", f4, m_state == S_FROZEN);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    rd_sel = 4'($urandom_range(15, 0));
    #1;
    check_all();
  endtask

  task automatic hold(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] iz,
                      input logic [7:0] st, input int n);
    a = ia; b = ib; z = iz; status = st; in_valid = 1'b1;
    repeat (n) cycle();
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
  endtask

  function automatic logic [31:0] pick_word();
    logic [7:0]  e;
    logic [22:0] m;
    case ($urandom_range(4, 0))
      0: e = 8'd0;
      1: e = 8'd1;
      2: e = 8'd254;
      3: e = 8'd255;
      default: e = 8'($urandom);
    endcase
    case ($urandom_range(2, 0))
      0: m = 23'd0;
      1: m = 23'h7FFFFF;
      default: m = 23'($urandom);
    endcase
    return {1'($urandom), e, m};
  endfunction

  function automatic logic [7:0] pick_status();
    logic [7:0] s;
    s = 8'd0;
    for (int i = 0; i < 8; i++) s[i] = ($urandom_range(3, 0) == 0);
    return s;
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; freeze_on_err = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; z = '0; status = 8'd0; rd_sel = 4'd0;
    model_reset();
    repeat (2) cycle();
    rst = 1'b0;

    // Disabled: violations on the bus are ignored
    hold(32'h0, 32'h0, 32'h0, 8'h30, 4);
    // Enabled stream, then reset while operations are in flight
    en = 1'b1;
    hold(32'h3F800000, 32'h40000000, 32'h00000000, 8'h30, 5);
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    hold(32'h3F800000, 32'h40000000, 32'h00000000, 8'h30, 6);

    // NaN rule: 0 x inf is legal, 1.0 x inf is not
    pulse_clr();
    hold(32'h00000000, 32'h7F800000, 32'h7FC00000, 8'h08, 5);
    hold(32'h3F800000, 32'h7F800000, 32'h7FC00000, 8'h08, 5);

    // huge/tiny boundaries
    pulse_clr();
    hold(32'h0, 32'h0, 32'h7F7FFFFF, 8'h02, 4);
    hold(32'h0, 32'h0, 32'h7F7FFFFE, 8'h02, 4);
    pulse_clr();
    hold(32'h0, 32'h0, 32'h00800000, 8'h04, 4);
    hold(32'h0, 32'h0, 32'h00800001, 8'h04, 4);

    // Freeze on error, then release with clr
    pulse_clr();
    freeze_on_err = 1'b1;
    hold(32'h0, 32'h0, 32'h00000000, 8'h30, 9);
    pulse_clr();
    freeze_on_err = 1'b0;
    hold(32'h0, 32'h0, 32'h00000000, 8'h00, 3);

    // Long run of R0 violations to saturate the narrow counters
    pulse_clr();
    hold(32'h0, 32'h0, 32'h00000000, 8'h30, 24);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      en       = ($urandom_range(15, 0) != 0);
      clr      = ($urandom_range(63, 0) == 0);
      rst      = ($urandom_range(299, 0) == 0);
      if ($urandom_range(99, 0) == 0) freeze_on_err = ~freeze_on_err;
      in_valid = ($urandom_range(3, 0) != 0);
      a        = pick_word();
      b        = pick_word();
      z        = pick_word();
      status   = pick_status();
      cycle();
    end
    rst = 1'b0; clr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
